// File: rtl/lsu_ctrl_pkg.sv
// Shared types, codes and helpers for the load/store sequencer.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

  // Load funct3 codes; store codes share the size bits [1:0] (sb/sh/sw/sd = 0..3).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // Fields of an accepted request that outlive the IDLE cycle.
  typedef struct packed {
    logic       wen;
    logic [2:0] funct3;
    logic [2:0] off;
    logic [4:0] rd;
  } req_t;

  // Byte-enable pattern for a lane-0 access of 1/2/4/8 bytes.
  function automatic logic [7:0] wmask_base(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Stores have no unsigned variants; loads reject only 111.
  function automatic logic f3_illegal(input logic wen, input logic [2:0] f3);
    return wen ? f3[2] : (f3 == F3_BAD);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus: request channel with valid/ready, read-data return with rvalid.
interface lsu_ctrl_if #(parameter int XLEN = 64);
  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_fmt.sv
// Load formatter: pick the addressed bytes out of the doubleword and extend.
module lsu_load_fmt
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] raw;

  assign raw = rdata >> {off, 3'b000};

  // Truncate to the access size, then sign- or zero-extend.
  always_comb begin
    wb_data = raw;
    case (funct3)
      F3_LB:   wb_data = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LH:   wb_data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LW:   wb_data = {{(XLEN-32){raw[31]}}, raw[31:0]};
      F3_LBU:  wb_data = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LHU:  wb_data = {{(XLEN-16){1'b0}}, raw[15:0]};
      F3_LWU:  wb_data = {{(XLEN-32){1'b0}}, raw[31:0]};
      default: wb_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: validate, align, run the bus handshake, format loads.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            stall,
  lsu_ctrl_if.master      mem,
  output logic            wb_valid,
  output logic [4:0]      wb_waddr,
  output logic [XLEN-1:0] wb_wdata,
  output logic            done,
  output logic            err_valid,
  output logic [1:0]      err_cause
);

  // One spare bit so the counter never wraps past the abort threshold.
  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [7:0]      wmask_q, wmask_d;
  cause_e          cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic [2:0]      off;
  logic [1:0]      size;
  logic            tmo;

  assign off  = req_addr[2:0];
  assign size = req_funct3[1:0];
  assign tmo  = (cnt_q >= CW'(TIMEOUT - 1));

  // Next-state and datapath capture; the awaited bus event always beats the timeout.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wmask_d = wmask_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_q) begin
          req_d.wen    = req_wen;
          req_d.funct3 = req_funct3;
          req_d.off    = off;
          req_d.rd     = req_rd;
          addr_d       = {req_addr[XLEN-1:3], 3'b000};
          wdata_d      = req_wdata << {off, 3'b000};
          wmask_d      = wmask_base(size) << off;
          cnt_d        = '0;
          cause_d      = CAUSE_NONE;
          if (f3_illegal(req_wen, req_funct3)) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_DONE;
          end else if (misaligned(size, off)) begin
            cause_d = CAUSE_MISALIGN;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem.mem_ready) begin
          state_d = req_q.wen ? S_DONE : S_RESP;
        end else if (tmo) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (mem.mem_rvalid) begin
          rdata_d = mem.mem_rdata;
          state_d = S_DONE;
        end else if (tmo) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-request registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wmask_q <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wmask_q <= wmask_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  lsu_load_fmt #(.XLEN(XLEN)) u_fmt (
    .rdata   (rdata_q),
    .off     (req_q.off),
    .funct3  (req_q.funct3),
    .wb_data (wb_wdata)
  );

  assign req_ready     = rdy_q && (state_q == S_IDLE);
  assign stall         = ((state_q == S_IDLE) && req_valid) ||
                         (state_q == S_REQ) || (state_q == S_RESP);
  assign mem.mem_valid = (state_q == S_REQ);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wen   = req_q.wen;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wmask = wmask_q;
  assign done          = (state_q == S_DONE);
  assign err_valid     = done && (cause_q != CAUSE_NONE);
  assign err_cause     = cause_q;
  assign wb_valid      = done && !req_q.wen && (cause_q == CAUSE_NONE) && (req_q.rd != 5'd0);
  assign wb_waddr      = req_q.rd;

endmodule
